if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
// - Parametrised instruction-fetch stage for the 5-stage RV32 pipeline.
// - Replaces the single PC register and IF/ID latch with three parts: a PC generator,
//   an in-order pipelined instruction-memory request/response port, and a DEPTH-entry
//   prefetch queue feeding decode.
// - Handles branch/jump redirects and interrupt/mret vectoring by flushing the queue
//   and discarding stale in-flight responses.
// PARAMETERS
// - XLEN      32  data/address width
// - DEPTH     4   prefetch queue entries; also the cap on queue entries + in-flight requests (>=2)
// - RESET_PC  0   fetch address after reset
// PORTS
// - clk             in   1     clock
// - rst             in   1     synchronous, active-high reset
// - imem_req_valid  out  1     fetch request valid
// - imem_req_ready  in   1     memory accepts request
// - imem_req_addr   out  XLEN  fetch address, word aligned
// - imem_rsp_valid  in   1     response valid; in order; >=1 cycle after its request
// - imem_rsp_data   in   32    instruction word
// - redir_valid     in   1     branch taken / jump from MEM stage
// - redir_pc        in   XLEN  redirect target
// - intr_valid      in   1     interrupt or mret vector request from CSR
// - intr_pc         in   XLEN  vector / epc target
// - id_valid        out  1     queue head valid toward decode
// - id_ready        in   1     decode accepts (0 = stall_id)
// - id_inst         out  32    head instruction; 32'h00000013 (NOP) when ~id_valid
// - id_pc           out  XLEN  head PC; 0 when ~id_valid
// - occupancy       out  $clog2(DEPTH+1)  queue entries, for debug/perf
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, drop_cnt=0.
//   Outputs after reset: id_valid=0, imem_req_valid=0, id_inst=NOP, id_pc=0, occupancy=0.
// - Target select: intr_valid has priority over redir_valid.
//   - Target bits [1:0] are forced to 0.
//   - "kill" = intr_valid | redir_valid.
// - Issue:
//   - imem_req_valid = ~kill & (occupancy + inflight < DEPTH).
//   - imem_req_addr = fetch_pc.
//   - On handshake: fetch_pc += 4, inflight += 1.
// - Response handling: a response always decrements inflight.
//   - If drop_cnt != 0 or kill: the word is discarded; drop_cnt decrements if nonzero.
//   - Otherwise: push {rsp_pc, imem_rsp_data} and rsp_pc += 4.
// - Pop: id_valid & id_ready pops the head.
//   - Push and pop in the same cycle are allowed when full or empty.
//   - No combinational rsp->id bypass: a word pushed in cycle N appears at the head in N+1 at the earliest.
// - Kill in cycle N:
//   - Queue cleared at N+1 (any pop at N still counts).
//   - fetch_pc and rsp_pc load the target.
//   - drop_cnt := inflight after the N update, so every outstanding response is discarded.
// - Redirect latency with a 1-cycle memory:
//   - kill at N; request at N+1; response at N+2; id_valid at N+3.
// - Stall (id_ready=0): the queue fills, issue halts at the DEPTH cap, nothing is lost.
// - Wrap: fetch_pc wraps modulo 2^XLEN. Queue pointers wrap modulo DEPTH.
// - Counters (inflight, drop_cnt, occupancy) are $clog2(DEPTH+1) bits.
//   They never exceed DEPTH; assert it.
// - Reset mid-operation overrides kill and handshakes.
//   Responses to pre-reset requests must not arrive after reset; the memory model is reset too.
// STRUCTURE
// - pipeline_pkg:
//   - NOP_INST = 32'h00000013
//   - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] inst;}
//   - typedef fetch_state_t {FETCH_RUN, FETCH_DRAIN}
// - Sub-module: sync_fifo #(WIDTH, DEPTH).
//   - Synchronous clear input.
//   - Push/pop/full/empty/count outputs.
// - Top level holds the PC generator, inflight/drop counters and kill logic.
//   - FSM: FETCH_RUN -> FETCH_DRAIN on kill while inflight != 0.
//   - FETCH_DRAIN -> FETCH_RUN when drop_cnt reaches 0.
//   - Issue continues in FETCH_DRAIN.
// TESTING
// - Reset, 1-cycle memory, id_ready=1:
//   - id_pc sequence 0,4,8,...
//   - First id_valid at cycle 3 after rst deasserts.
//   - Throughput 1 instruction per cycle.
// - id_ready=0 for 20 cycles: occupancy saturates at 4 (DEPTH=4), issue stops.
//   Release: PCs continue without gap or repeat.
// - 3-cycle memory, 3 requests in flight, redir_valid with redir_pc=0x100:
//   - 3 responses dropped.
//   - Next id_pc=0x100, then 0x104.
// - redir_valid (0x100) and intr_valid (0x800) in the same cycle: next id_pc=0x800.
// - Response arrives in the kill cycle: it is dropped, drop_cnt correct, no stale PC reaches decode.
// - Random req_ready/rsp latency and random kills over 10k cycles, against a reference PC model:
//   - Every id_pc/id_inst pair matches memory[id_pc].
//   - Counters stay <= DEPTH.

Source files
------------

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   DEF_XLEN      : default address/data width of the pipeline
//   NOP_INST      : addi x0,x0,0, presented to decode when no instruction is available
//   fetch_entry_t : one prefetch-queue entry {pc, inst}
//   fetch_state_t : fetch-control FSM states
package if_prefetch_unit_pkg;

    localparam int DEF_XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory request/response port,
// redirect and interrupt vector inputs, and the decode-facing queue head.
//   master : the fetch unit
//   slave  : memory / MEM stage / CSR / decode side
interface if_prefetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            intr_valid;
    logic [XLEN-1:0] intr_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic [CW-1:0]   occupancy;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, occupancy,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redir_valid, redir_pc, intr_valid, intr_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, occupancy,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redir_valid, redir_pc, intr_valid, intr_pc, id_ready
    );
endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO used as the prefetch queue.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous flush (empties the queue)
//   push/push_data, pop/pop_data : write and read ports; pop_data shows the head
//   full, empty, count           : fill status
// Push is accepted when full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Accept/status decode.
    always_comb begin
        empty     = (count_r == '0);
        full      = (count_r == CW'(DEPTH));
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        count     = count_r;
        pop_data  = mem_r[rd_ptr_r];
    end

    // Pointer and count registers; clear wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clr && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC generator, in-order pipelined instruction-memory
// port and a DEPTH-entry prefetch queue feeding decode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_prefetch_unit_if.master (imem req/rsp, redirect, interrupt, decode head)
// A kill (interrupt vector or redirect) flushes the queue, reloads both PCs and
// arms a drop counter so that every response still in flight is discarded.

// Invariant checks for the fetch stage.
module if_prefetch_unit_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] occupancy,
    input logic          push,
    input logic          pop,
    input logic          full
);
    a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight <= CW'(DEPTH));
    a_drop_max:     assert property (@(posedge clk) disable iff (rst) drop_cnt <= inflight);
    a_occ_max:      assert property (@(posedge clk) disable iff (rst) occupancy <= CW'(DEPTH));
    a_cap:          assert property (@(posedge clk) disable iff (rst)
                        ({1'b0, occupancy} + {1'b0, inflight}) <= (CW + 1)'(DEPTH));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    if_prefetch_unit_if.master bus
);
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam int              FW   = XLEN + 32;
    localparam logic [CW:0]     CAP  = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    fetch_state_t    state_r, state_nxt_s;
    logic [XLEN-1:0] fetch_pc_r, rsp_pc_r, target_s;
    logic [CW-1:0]   inflight_r, drop_cnt_r, inflight_nxt_s, drop_nxt_s, occ_s;
    logic            kill_s, req_fire_s, push_s, pop_s, full_s, empty_s;
    logic [FW-1:0]   head_s;

    // Kill target select: interrupt vector beats redirect, always word aligned.
    always_comb begin
        kill_s = bus.intr_valid | bus.redir_valid;
        if (bus.intr_valid) begin
            target_s = {bus.intr_pc[XLEN-1:2], 2'b00};
        end else if (bus.redir_valid) begin
            target_s = {bus.redir_pc[XLEN-1:2], 2'b00};
        end else begin
            target_s = fetch_pc_r;
        end
    end

    // Issue only while queue entries plus outstanding requests leave room for
    // every response, so a response can always be pushed.
    always_comb begin
        bus.imem_req_valid = ~rst & ~kill_s & (({1'b0, occ_s} + {1'b0, inflight_r}) < CAP);
        bus.imem_req_addr  = fetch_pc_r;
        req_fire_s         = bus.imem_req_valid & bus.imem_req_ready;
        push_s             = bus.imem_rsp_valid & ~kill_s & (drop_cnt_r == '0);
        pop_s              = ~empty_s & bus.id_ready;
    end

    // In-flight and drop counter next values; a kill arms drop_cnt with the
    // post-update in-flight count.
    always_comb begin
        case ({req_fire_s, bus.imem_rsp_valid})
            2'b10:   inflight_nxt_s = inflight_r + CW'(1);
            2'b01:   inflight_nxt_s = inflight_r - CW'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
        if (kill_s) begin
            drop_nxt_s = inflight_nxt_s;
        end else if (bus.imem_rsp_valid && (drop_cnt_r != '0)) begin
            drop_nxt_s = drop_cnt_r - CW'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Fetch-control FSM next state; issue is not blocked while draining.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH_RUN: begin
                if (kill_s && (inflight_nxt_s != '0)) begin
                    state_nxt_s = FETCH_DRAIN;
                end else begin
                    state_nxt_s = FETCH_RUN;
                end
            end
            FETCH_DRAIN: begin
                if (drop_nxt_s == '0) begin
                    state_nxt_s = FETCH_RUN;
                end else begin
                    state_nxt_s = FETCH_DRAIN;
                end
            end
            default: state_nxt_s = FETCH_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC generator and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= '0;
            drop_cnt_r <= '0;
        end else begin
            inflight_r <= inflight_nxt_s;
            drop_cnt_r <= drop_nxt_s;
            if (kill_s) begin
                fetch_pc_r <= target_s;
                rsp_pc_r   <= target_s;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + STEP;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + STEP;
                end
            end
        end
    end

    sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (kill_s),
        .push      (push_s),
        .push_data ({rsp_pc_r, bus.imem_rsp_data}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (occ_s)
    );

    // Decode-facing head: NOP and PC 0 when the queue is empty.
    always_comb begin
        bus.id_valid  = ~empty_s;
        bus.occupancy = occ_s;
        if (!empty_s) begin
            bus.id_inst = head_s[31:0];
            bus.id_pc   = head_s[FW-1:32];
        end else begin
            bus.id_inst = NOP_INST;
            bus.id_pc   = '0;
        end
    end

    if_prefetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .inflight  (inflight_r),
        .drop_cnt  (drop_cnt_r),
        .occupancy (occ_s),
        .push      (push_s),
        .pop       (pop_s),
        .full      (full_s)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: in-order memory model with
// configurable latency, epoch-tagged requests to recognise stale responses,
// and a scoreboard of expected {pc, inst} entries toward decode.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t sbq[$];
    logic [31:0]  post_kill[$];

    int checks = 0;
    int failures = 0;
    int cyc, epoch, last_due, first_valid_cyc, pops_total, total_pops, drops_since_kill;
    int lat_min, lat_max, rdy_pct, idr_pct;
    bit rst_cfg, chk_reset, kill_had_rsp;
    bit k_redir, k_intr;
    logic [31:0] k_rpc, k_ipc, exp_pc, exp_fetch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        pend_t        head;
        fetch_entry_t e;
        bit           rsp_now, kill, intr_now;
        logic [31:0]  tgt, rpc, ipc;
        int           d;
        @(posedge clk);
        #1;
        cyc++;
        rst             = rst_cfg;
        bus.redir_valid = k_redir;
        bus.redir_pc    = k_rpc;
        bus.intr_valid  = k_intr;
        bus.intr_pc     = k_ipc;
        kill            = k_redir | k_intr;
        intr_now        = k_intr;
        rpc             = k_rpc;
        ipc             = k_ipc;
        k_redir         = 1'b0;
        k_intr          = 1'b0;
        bus.imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
        bus.id_ready       = ($urandom_range(1, 100) <= idr_pct);
        rsp_now = 1'b0;
        if (!rst_cfg && pend.size() > 0 && pend[0].due <= cyc) begin
            head    = pend.pop_front();
            rsp_now = 1'b1;
        end
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? mem_word(head.addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        if (rst_cfg) begin
            if (chk_reset) begin
                check_eq("rst_id_valid", bus.id_valid, 1'b0);
                check_eq("rst_req_valid", bus.imem_req_valid, 1'b0);
                check_eq("rst_id_inst", bus.id_inst, NOP_INST);
                check_eq("rst_id_pc", bus.id_pc, 32'h0);
                check_eq("rst_occupancy", bus.occupancy, 3'd0);
            end
            pend.delete();
            sbq.delete();
            return;
        end
        if (kill) begin
            drops_since_kill = 0;
            kill_had_rsp     = rsp_now;
        end
        if (!bus.id_valid) begin
            check_eq("idle_inst", bus.id_inst, NOP_INST);
            check_eq("idle_pc", bus.id_pc, 32'h0);
        end
        check_eq("occupancy", bus.occupancy, sbq.size());
        check_eq("id_valid", bus.id_valid, sbq.size() != 0);
        if (bus.id_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
        if (bus.id_valid && bus.id_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            check_eq("id_pc", bus.id_pc, e.pc);
            check_eq("id_inst", bus.id_inst, e.inst);
            pops_total++;
            total_pops++;
            post_kill.push_back(bus.id_pc);
        end
        check_eq("cap", (bus.occupancy + pend.size() + rsp_now) <= DEPTH, 1'b1);
        if (rsp_now) begin
            if (!kill && head.epoch == epoch) begin
                check_eq("rsp_addr", head.addr, exp_pc);
                sbq.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end else begin
                drops_since_kill++;
            end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check_eq("req_addr", bus.imem_req_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: d});
        end
        if (kill) begin
            check_eq("req_in_kill", bus.imem_req_valid, 1'b0);
            sbq.delete();
            post_kill.delete();
            epoch++;
            tgt       = intr_now ? ipc : rpc;
            tgt[1:0]  = 2'b00;
            exp_pc    = tgt;
            exp_fetch = tgt;
        end
    endtask

    task automatic do_reset();
        rst_cfg   = 1'b1;
        chk_reset = 1'b0;
        step();
        step();
        chk_reset = 1'b1;
        step();
        chk_reset = 1'b0;
        rst_cfg   = 1'b0;
        cyc = 0; epoch = 0; last_due = 0; first_valid_cyc = 0;
        pops_total = 0; drops_since_kill = 0;
        exp_pc = 32'h0; exp_fetch = 32'h0;
        post_kill.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        bus.redir_valid = 1'b0; bus.redir_pc = 32'h0; bus.intr_valid = 1'b0; bus.intr_pc = 32'h0;
        bus.id_ready = 1'b0;
        k_redir = 1'b0; k_intr = 1'b0; k_rpc = 32'h0; k_ipc = 32'h0;
        total_pops = 0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; idr_pct = 100;
        do_reset();

        // Startup latency, in-order PCs, one instruction per cycle.
        run(22);
        check_eq("first_valid_cycle", first_valid_cyc, 3);
        check_eq("throughput", pops_total, 20);
        check_eq("seq_pc0", post_kill[0], 32'h0);
        check_eq("seq_pc5", post_kill[5], 32'h14);

        // Decode stall: queue saturates, issue stops, release resumes seamlessly.
        idr_pct = 0;
        run(20);
        check_eq("stall_occupancy", bus.occupancy, 3'd4);
        check_eq("stall_req_valid", bus.imem_req_valid, 1'b0);
        idr_pct = 100;
        run(20);

        // 3-cycle memory, redirect with three requests outstanding.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 50 && pend.size() != 3; i++) step();
        check_eq("three_inflight", pend.size(), 3);
        k_redir = 1'b1; k_rpc = 32'h100;
        step();
        for (int i = 0; i < 50 && post_kill.size() < 2; i++) step();
        check_eq("redir_pops", post_kill.size() >= 2, 1'b1);
        if (post_kill.size() >= 2) begin
            check_eq("redir_pc0", post_kill[0], 32'h100);
            check_eq("redir_pc1", post_kill[1], 32'h104);
        end
        check_eq("redir_drops", drops_since_kill, 3);

        // Redirect and interrupt together: interrupt wins.
        lat_min = 1; lat_max = 1;
        run(6);
        k_redir = 1'b1; k_rpc = 32'h100; k_intr = 1'b1; k_ipc = 32'h800;
        step();
        for (int i = 0; i < 20 && post_kill.size() < 1; i++) step();
        check_eq("prio_pops", post_kill.size() >= 1, 1'b1);
        if (post_kill.size() >= 1) check_eq("prio_pc", post_kill[0], 32'h800);

        // Response in the kill cycle is dropped; unaligned target is aligned.
        run(6);
        k_redir = 1'b1; k_rpc = 32'h203;
        step();
        for (int i = 0; i < 20 && post_kill.size() < 2; i++) step();
        check_eq("killrsp_seen", kill_had_rsp, 1'b1);
        check_eq("killrsp_drops", drops_since_kill, 1);
        check_eq("killrsp_pops", post_kill.size() >= 2, 1'b1);
        if (post_kill.size() >= 2) begin
            check_eq("killrsp_pc0", post_kill[0], 32'h200);
            check_eq("killrsp_pc1", post_kill[1], 32'h204);
        end

        // Random readiness, latency and kills, with a mid-run reset.
        lat_min = 1; lat_max = 4; rdy_pct = 70; idr_pct = 75;
        total_pops = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset();
            if ($urandom_range(1, 100) <= 3) begin
                int sel;
                sel     = $urandom_range(0, 2);
                k_redir = (sel != 1);
                k_intr  = (sel != 0);
                k_rpc   = $urandom;
                k_ipc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
            end
            step();
        end
        check_eq("random_progress", total_pops > 1000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
